// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_ex operand feeders: default widths/latency and the operand tuple.
package pipe_pkg;

    localparam int unsigned PipeN   = 10;
    localparam int unsigned PipeLat = 2;

    typedef struct packed {
        logic [PipeN-1:0] a;
        logic [PipeN-1:0] b;
        logic [PipeN-1:0] c;
        logic [PipeN-1:0] d;
    } operand_t;

    function automatic operand_t mk_tuple(input logic [PipeN-1:0] va, input logic [PipeN-1:0] vb,
                                          input logic [PipeN-1:0] vc, input logic [PipeN-1:0] vd);
        operand_t t;
        t.a = va;
        t.b = vb;
        t.c = vc;
        t.d = vd;
        return t;
    endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty come from the level, not pointer equality.
module pipe_sync_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned Width = 4 * PipeN,
    parameter int unsigned Depth = 4,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned LvlW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [LvlW-1:0]  level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_en, pop_en;

    assign full_o  = (level_q == LvlW'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        push_en = push_i && !full_o;
        pop_en  = pop_i && !empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        // Depth is a power of two, so pointer wrap is the natural overflow.
        if (push_en) wptr_d = wptr_q + AddrW'(1);
        if (pop_en)  rptr_d = rptr_q + AddrW'(1);
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pipe_operand_feeder.sv
// Operand-issue front end for pipe_ex: FIFO-buffered tuples, one issue per clock,
// with a valid bit delayed by the pipe_ex latency to qualify the returned result.
module pipe_operand_feeder
    import pipe_pkg::*;
#(
    parameter int unsigned n     = PipeN,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = PipeLat,
    localparam int unsigned LvlW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [n-1:0]    in_a,
    input  logic [n-1:0]    in_b,
    input  logic [n-1:0]    in_c,
    input  logic [n-1:0]    in_d,
    output logic [n-1:0]    a,
    output logic [n-1:0]    b,
    output logic [n-1:0]    c,
    output logic [n-1:0]    d,
    output logic            issue_valid,
    input  logic [n-1:0]    f,
    output logic [n-1:0]    res_f,
    output logic            res_valid,
    output logic [LvlW-1:0] level
);

    logic [4*n-1:0] wdata, rdata;
    logic           full, empty, push_en, pop_en;
    logic [4*n-1:0] ops_q, ops_d;
    logic           issue_valid_q;
    logic [LAT-1:0] vsr_q, vsr_d;

    assign wdata    = {in_a, in_b, in_c, in_d};
    assign in_ready = !full;
    assign push_en  = in_valid && !full;
    // pipe_ex never stalls, so anything buffered issues immediately.
    assign pop_en   = !empty;

    pipe_sync_fifo #(
        .Width (4 * n),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_en),
        .wdata_i (wdata),
        .pop_i   (pop_en),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ops_d    = pop_en ? rdata : ops_q;
        vsr_d    = vsr_q << 1;
        vsr_d[0] = issue_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q         <= '0;
            issue_valid_q <= 1'b0;
            vsr_q         <= '0;
        end else begin
            ops_q         <= ops_d;
            issue_valid_q <= pop_en;
            vsr_q         <= vsr_d;
        end
    end

    assign a           = ops_q[4*n-1 -: n];
    assign b           = ops_q[3*n-1 -: n];
    assign c           = ops_q[2*n-1 -: n];
    assign d           = ops_q[n-1 -: n];
    assign issue_valid = issue_valid_q;
    assign res_valid   = vsr_q[LAT-1];
    assign res_f       = f;

endmodule

// File: tb/tb_pipe_operand_feeder.sv
// Directed, table-driven bench for pipe_operand_feeder with hand-written fill/wrap/reset sequences.
module tb_pipe_operand_feeder;
    import pipe_pkg::*;

    localparam int unsigned Lat = PipeLat;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [9:0]     in_a, in_b, in_c, in_d;
    logic [9:0]     a, b, c, d;
    logic           issue_valid;
    logic [9:0]     f, res_f;
    logic           res_valid;
    logic [2:0]     level;
    operand_t       obs;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic     vld;
        operand_t tup;
        logic     exp_iv;
        operand_t exp_tup;
        logic     exp_rv;
        logic [2:0] exp_lvl;
        logic     exp_rdy;
    } vec_t;

    vec_t     vecs [14];
    operand_t stream [16];
    operand_t fill [5];

    always #5 clk = ~clk;

    assign obs = {a, b, c, d};

    pipe_operand_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_d        (in_d),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .issue_valid (issue_valid),
        .f           (f),
        .res_f       (res_f),
        .res_valid   (res_valid),
        .level       (level)
    );

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_iv, input operand_t exp_tup,
                             input logic exp_rv, input logic [2:0] exp_lvl, input logic exp_rdy);
        chk({tag, ".issue_valid"}, 40'(issue_valid), 40'(exp_iv));
        chk({tag, ".abcd"}, 40'(obs), 40'(exp_tup));
        chk({tag, ".res_valid"}, 40'(res_valid), 40'(exp_rv));
        chk({tag, ".level"}, 40'(level), 40'(exp_lvl));
        chk({tag, ".in_ready"}, 40'(in_ready), 40'(exp_rdy));
    endtask

    task automatic drive(input logic v, input operand_t t);
        in_valid = v;
        in_a = t.a;
        in_b = t.b;
        in_c = t.c;
        in_d = t.d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    // Push cnt tuples from stream[] on consecutive edges, then drain.
    task automatic run_stream(input string tag, input int cnt);
        for (int e = 1; e <= cnt + int'(Lat) + 2; e++) begin
            drive(e <= cnt, (e <= cnt) ? stream[e-1] : '0);
            step();
            chk({tag, ".in_ready"}, 40'(in_ready), 40'(1));
            chk({tag, ".level"}, 40'(level), (e <= cnt) ? 40'(1) : 40'(0));
            chk({tag, ".issue_valid"}, 40'(issue_valid), 40'(e >= 2 && e <= cnt + 1));
            if (e >= 2 && e <= cnt + 1) chk({tag, ".abcd"}, 40'(obs), 40'(stream[e-2]));
            chk({tag, ".res_valid"}, 40'(res_valid),
                40'(e >= 2 + int'(Lat) && e <= cnt + 1 + int'(Lat)));
        end
    endtask

    initial begin
        operand_t z, t1, t2, t3, x, y, zz, w;
        z  = '0;
        t1 = mk_tuple(10'd10, 10'd12, 10'd6, 10'd3);
        t2 = mk_tuple(10'd30, 10'd1, 10'd2, 10'd4);
        t3 = mk_tuple(10'd8, 10'd15, 10'd5, 10'd0);

        // Single tuple, then gap sequence (LAT = 2).
        vecs[0]  = '{1'b1, t1, 1'b0, z,  1'b0, 3'd1, 1'b1};
        vecs[1]  = '{1'b0, z,  1'b1, t1, 1'b0, 3'd0, 1'b1};
        vecs[2]  = '{1'b0, z,  1'b0, t1, 1'b0, 3'd0, 1'b1};
        vecs[3]  = '{1'b0, z,  1'b0, t1, 1'b1, 3'd0, 1'b1};
        vecs[4]  = '{1'b0, z,  1'b0, t1, 1'b0, 3'd0, 1'b1};
        vecs[5]  = '{1'b1, t2, 1'b0, t1, 1'b0, 3'd1, 1'b1};
        vecs[6]  = '{1'b0, z,  1'b1, t2, 1'b0, 3'd0, 1'b1};
        vecs[7]  = '{1'b0, z,  1'b0, t2, 1'b0, 3'd0, 1'b1};
        vecs[8]  = '{1'b0, z,  1'b0, t2, 1'b1, 3'd0, 1'b1};
        vecs[9]  = '{1'b1, t3, 1'b0, t2, 1'b0, 3'd1, 1'b1};
        vecs[10] = '{1'b0, z,  1'b1, t3, 1'b0, 3'd0, 1'b1};
        vecs[11] = '{1'b0, z,  1'b0, t3, 1'b0, 3'd0, 1'b1};
        vecs[12] = '{1'b0, z,  1'b0, t3, 1'b1, 3'd0, 1'b1};
        vecs[13] = '{1'b0, z,  1'b0, t3, 1'b0, 3'd0, 1'b1};

        rst = 1'b1;
        f   = 10'h000;
        drive(1'b0, z);
        #2;
        check_all("reset", 1'b0, z, 1'b0, 3'd0, 1'b1);
        #5;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].vld, vecs[i].tup);
            f = 10'(i * 37 + 5);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_iv, vecs[i].exp_tup, vecs[i].exp_rv,
                      vecs[i].exp_lvl, vecs[i].exp_rdy);
            chk($sformatf("vec%0d.res_f", i), 40'(res_f), 40'(i * 37 + 5));
        end

        // Sustained stream of 8.
        stream[0] = t1;
        stream[1] = mk_tuple(10'd10, 10'd10, 10'd5, 10'd3);
        stream[2] = mk_tuple(10'd20, 10'd11, 10'd1, 10'd4);
        stream[3] = mk_tuple(10'd7, 10'd9, 10'd2, 10'd1);
        stream[4] = mk_tuple(10'd100, 10'd200, 10'd300, 10'd400);
        stream[5] = mk_tuple(10'd1023, 10'd0, 10'd512, 10'd1);
        stream[6] = mk_tuple(10'd5, 10'd6, 10'd7, 10'd8);
        stream[7] = mk_tuple(10'd40, 10'd41, 10'd42, 10'd43);
        run_stream("stream8", 8);

        // Wrap-around: 9 tuples with a = 1..9 through a 4-entry FIFO.
        for (int k = 1; k <= 9; k++)
            stream[k-1] = mk_tuple(10'(k), 10'(k + 16), 10'(k * 3), 10'(1023 - k));
        run_stream("wrap9", 9);

        // Fill: hold off pops so the FIFO reaches DEPTH.
        pulse_reset();
        for (int k = 0; k < 5; k++)
            fill[k] = mk_tuple(10'(11 + k), 10'(k), 10'(2 * k), 10'(900 + k));
        force dut.pop_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, fill[k]);
            step();
            check_all($sformatf("fill%0d", k), 1'b0, z, 1'b0, 3'(k + 1), k != 3);
        end
        drive(1'b1, fill[4]);
        step();
        check_all("full_hold0", 1'b0, z, 1'b0, 3'd4, 1'b0);
        step();
        check_all("full_hold1", 1'b0, z, 1'b0, 3'd4, 1'b0);
        release dut.pop_en;
        step();
        check_all("drain0", 1'b1, fill[0], 1'b0, 3'd3, 1'b1);
        step();
        check_all("drain1", 1'b1, fill[1], 1'b0, 3'd3, 1'b1);
        drive(1'b0, z);
        step();
        check_all("drain2", 1'b1, fill[2], 1'b1, 3'd2, 1'b1);
        step();
        check_all("drain3", 1'b1, fill[3], 1'b1, 3'd1, 1'b1);
        step();
        check_all("drain4", 1'b1, fill[4], 1'b1, 3'd0, 1'b1);
        step();
        check_all("drain5", 1'b0, fill[4], 1'b1, 3'd0, 1'b1);

        // Asynchronous reset with level = 3 and vsr non-zero.
        pulse_reset();
        x  = mk_tuple(10'd1, 10'd2, 10'd3, 10'd4);
        y  = mk_tuple(10'd55, 10'd66, 10'd77, 10'd88);
        zz = mk_tuple(10'd9, 10'd8, 10'd7, 10'd6);
        w  = mk_tuple(10'd500, 10'd501, 10'd502, 10'd503);
        drive(1'b1, x);
        step();
        drive(1'b1, y);
        step();
        check_all("pre_rst0", 1'b1, x, 1'b0, 3'd1, 1'b1);
        force dut.pop_en = 1'b0;
        drive(1'b1, zz);
        step();
        drive(1'b1, w);
        step();
        check_all("pre_rst1", 1'b0, x, 1'b1, 3'd3, 1'b1);
        drive(1'b0, z);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, z, 1'b0, 3'd0, 1'b1);
        release dut.pop_en;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_all($sformatf("post_rst%0d", k), 1'b0, z, 1'b0, 3'd0, 1'b1);
        end
        drive(1'b1, y);
        step();
        check_all("cold0", 1'b0, z, 1'b0, 3'd1, 1'b1);
        drive(1'b0, z);
        step();
        check_all("cold1", 1'b1, y, 1'b0, 3'd0, 1'b1);
        step();
        check_all("cold2", 1'b0, y, 1'b0, 3'd0, 1'b1);
        step();
        check_all("cold3", 1'b0, y, 1'b1, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
